fe_fetch_ctrl: RTL
==================

# fe_fetch_ctrl

Fetch-side consumer of the writeback EIP redirect. Owns the fetch line pointer and issues line-aligned requests to the I-cache over a req/ack handshake. Buffers returned 16-byte lines in a small line FIFO for decode. On a writeback redirect it squashes buffered lines, drains any outstanding I-cache request, and restarts fetch at `CS base + EIP`.

## Interface
- `RESET_VEC`, default 32'hFFFF_FFF0: linear fetch address after reset.
- `clk  in  1`: single clock, rising edge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `r_EIP  in  32`: architectural EIP from the writeback EIP register.
- `ld_eip  in  2`: bit 1 = writeback redirect (branch/flag-mispredict target valid in `r_EIP`). Bit 0 = decode advance, ignored here.
- `r_CS_base  in  32`: code segment base.
- `ic_req  out  1`: I-cache request, registered.
- `ic_addr  out  32`: request line address, `[3:0]` always 0.
- `ic_ack  in  1`: one-cycle acknowledge. `ic_data` is valid in the same cycle.
- `ic_data  in  128`: returned line.
- `de_consume  in  1`: decode is done with the head line (pop).
- `fe_line_v  out  1`: head line valid.
- `fe_line  out  128`: head line data.
- `fe_line_addr  out  32`: head line linear address.
- `fe_ofs  out  4`: first valid byte of the head line.
- `fe_busy  out  1`: high while in DRAIN.

## Operation
- Linear target is `(r_CS_base + r_EIP)` mod 2^32.
- Line address is `target & ~32'hF`; start offset is `target[3:0]`.
- States:
  - RUN: normal fetch.
  - DRAIN: a redirect arrived while a request was outstanding without ack. `ic_req` and `ic_addr` are held at the stale values until `ic_ack`. The returned data is discarded. Go to RUN on ack.
- Handshake:
  - Once `ic_req` is asserted, `ic_addr` is stable and `ic_req` stays high until `ic_ack`. No withdrawal, even on redirect.
  - `ic_ack` with `ic_req` low is ignored.
- Request issue: in RUN, `ic_req` is high next cycle iff `count_next < DEPTH`.
  - `count_next` accounts for this cycle's push and pop.
  - Back-to-back requests are allowed: on ack, `ic_addr` advances by 16 with wrap mod 2^32.
- Push on `ic_ack` in RUN with no redirect in the same cycle.
  - The entry stores data, address and offset.
  - Offset is the redirect/reset offset for the first line after a redirect or reset, else 0.
- Pop on `de_consume & fe_line_v`. `de_consume` with an empty FIFO is ignored.
- Redirect (`ld_eip[1]`) in cycle N:
  - FIFO is flushed and the fetch pointer is loaded from the target. This overrides push/pop in cycle N.
  - `ic_req` low or `ic_ack` in N: RUN; the new request is issued at N+1.
  - Request outstanding without ack in N: DRAIN.
- Redirect while in DRAIN: the target is overwritten and the block stays in DRAIN. The latest redirect wins.

## Timing
- Reset values:
  - `ic_req`=0, `ic_addr`=`RESET_VEC & ~F`.
  - `fe_line_v`=0, `fe_line`=0, `fe_line_addr`=0, `fe_ofs`=0, `fe_busy`=0.
  - FIFO empty, state RUN, offset = `RESET_VEC[3:0]`.
- First `ic_req` is asserted in the first cycle after `rst_n` deasserts.
- Reset mid-operation clears everything immediately. An outstanding I-cache request is abandoned; the I-cache is reset by the same `rst_n`.
- Ack→visible latency: ack in N gives `fe_line_v` at N+1 when the FIFO was empty.
- Pop: `de_consume` in N advances the head at N+1.
- Redirect to first new request:
  - 1 cycle with no request outstanding.
  - ack cycle + 1 when draining.
- Full: at DEPTH entries `ic_req` stays low. A pop in N re-enables `ic_req` at N+1.

## Configuration
- `FE_DUAL_LINE_EN` defined: DEPTH=2. Fetch runs one line ahead of decode.
- `FE_DUAL_LINE_EN` undefined: DEPTH=1. A new request is issued only after the head is consumed (or in the same cycle it is consumed). Handshake and redirect rules are unchanged.

## Structure
- Package `fe_pkg` holds:
  - `FE_LINE_BYTES`=16 and `FE_LINE_W`=128.
  - `FE_DEPTH`, derived from the macro.
  - `fe_state_t` with RUN and DRAIN.
  - `fe_entry_t` with data, addr and ofs.
- Sub-module `fe_line_fifo` implements the DEPTH-entry FIFO with `push`, `pop`, `flush`, `count` and the head entry. The controller keeps the FSM, fetch pointer and handshake.

## Test plan
- Reset with `RESET_VEC`=FFFF_FFF0:
  - Cycle 1: `ic_req`=1 with `ic_addr`=FFFF_FFF0.
  - Ack, then the next `ic_addr`=0000_0000 (wrap).
  - Head `fe_ofs`=0.
- Redirect with nothing outstanding: CS=0000_1000, EIP=0000_0235.
  - Next cycle: `fe_line_v`=0, `ic_addr`=0000_1230.
  - After ack: `fe_ofs`=5. The following line has `fe_ofs`=0 and address 0000_1240.
- Redirect while a request to 0000_2000 is outstanding:
  - `fe_busy`=1 and `ic_addr` is held at 0000_2000.
  - Ack 3 cycles later: the data is not pushed, and `ic_addr`=new target line on the next cycle.
- Redirect in the same cycle as ack and `de_consume`: no push, FIFO empty next cycle, new request issued next cycle.
- Full FIFO (2 lines, `FE_DUAL_LINE_EN`): `ic_req` stays low. `de_consume` pulse → `ic_req`=1 next cycle. Repeat with the macro undefined: depth 1.
- Two redirects in DRAIN (targets 0000_3000 then 0000_4008):
  - After ack: request 0000_4000, head `fe_ofs`=8.

Source files
------------

// File: rtl/fe_pkg.sv
// fe_pkg: shared types and constants for the fetch-side controller.
//
// Contents:
//   FE_LINE_BYTES / FE_LINE_W : I-cache line geometry (16 bytes, 128 bits)
//   FE_DEPTH                  : line FIFO depth. It is 2 when FE_DUAL_LINE_EN
//                               is defined, so fetch can run one line ahead of
//                               decode. Otherwise it is 1.
//   FE_CNT_W                  : width of the FIFO occupancy counter
//   fe_state_t                : controller FSM states (RUN, DRAIN)
//   fe_entry_t                : one buffered line (data, linear address, start offset)
//   fe_line_of()              : line-aligns a linear address
//
// Configuration macro: FE_DUAL_LINE_EN
package fe_pkg;

  localparam int FE_LINE_BYTES = 16;
  localparam int FE_LINE_W     = 128;

`ifdef FE_DUAL_LINE_EN
  localparam int FE_DEPTH = 2;
`else
  localparam int FE_DEPTH = 1;
`endif

  localparam int FE_CNT_W = $clog2(FE_DEPTH + 1);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } fe_state_t;

  typedef struct packed {
    logic [FE_LINE_W-1:0] data;
    logic [31:0]          addr;
    logic [3:0]           ofs;
  } fe_entry_t;

  function automatic logic [31:0] fe_line_of(input logic [31:0] lin);
    return lin & ~32'hF;
  endfunction

endpackage

// File: rtl/fe_line_fifo.sv
// fe_line_fifo: DEPTH-entry line buffer between the I-cache and decode.
//
// Entries are kept in a shift arrangement: the head is always mem[0].
// A pop shifts the remaining entries down, and a push writes at the first free
// slot after that shift. Flush empties the buffer and takes priority over
// push and pop. Pop on an empty buffer is ignored. The head output reads as
// zero while the buffer is empty.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write one entry (caller guarantees room)
//   pop        : drop the head entry
//   flush      : discard all entries
//   count      : current occupancy
//   head_v     : head entry valid
//   head       : head entry (zero when empty)
//
// Configuration macro: FE_DUAL_LINE_EN (through fe_pkg::FE_DEPTH)
import fe_pkg::*;

module fe_line_fifo #(
  parameter int DEPTH = FE_DEPTH,
  parameter int CW    = FE_CNT_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fe_entry_t     din,
  output logic [CW-1:0] count,
  output logic          head_v,
  output fe_entry_t     head
);

  fe_entry_t     mem [DEPTH];
  logic          do_pop;
  logic [CW-1:0] wr_idx;

  assign do_pop = pop & (count != '0);
  // The write slot is computed after this cycle's pop has shifted the buffer.
  assign wr_idx = count - CW'(do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      if (do_pop) begin
        for (int i = 0; i < DEPTH - 1; i++) mem[i] <= mem[i+1];
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (push && (wr_idx == CW'(i))) mem[i] <= din;
      end
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

  assign head_v = (count != '0);
  assign head   = head_v ? mem[0] : '0;

endmodule

// File: rtl/fe_fetch_ctrl.sv
// fe_fetch_ctrl: fetch line pointer, I-cache request handshake and writeback
// redirect handling. Returned 16-byte lines are buffered in fe_line_fifo for
// decode.
//
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   r_EIP, r_CS_base: redirect target components (target = CS base + EIP)
//   ld_eip          : [1] writeback redirect, [0] decode advance (unused here)
//   ic_req, ic_addr : registered I-cache line request
//   ic_ack, ic_data : one-cycle acknowledge with the returned line
//   de_consume      : decode pops the head line
//   fe_line_v, fe_line, fe_line_addr, fe_ofs : head line presented to decode
//   fe_busy         : high in DRAIN. It mirrors the FSM state one-to-one.
//
// Handshake: once ic_req rises, ic_addr is frozen and ic_req stays high
// until the cycle ic_ack is seen. A redirect never withdraws a request.
// Instead, the stale request is drained and its data dropped. ic_ack with
// ic_req low is ignored.
//
// Configuration macro: FE_DUAL_LINE_EN (FIFO depth 2 instead of 1)
import fe_pkg::*;

module fe_fetch_ctrl #(
  parameter logic [31:0] RESET_VEC = 32'hFFFF_FFF0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          r_EIP,
  input  logic [1:0]           ld_eip,
  input  logic [31:0]          r_CS_base,
  output logic                 ic_req,
  output logic [31:0]          ic_addr,
  input  logic                 ic_ack,
  input  logic [FE_LINE_W-1:0] ic_data,
  input  logic                 de_consume,
  output logic                 fe_line_v,
  output logic [FE_LINE_W-1:0] fe_line,
  output logic [31:0]          fe_line_addr,
  output logic [3:0]           fe_ofs,
  output logic                 fe_busy
);

  fe_state_t           state_q, state_d;
  logic                req_q, req_d;
  logic [31:0]         addr_q, addr_d;  // outstanding line, or next line to fetch
  logic [31:0]         tgt_q, tgt_d;    // restart line held while draining
  logic [3:0]          ofs_q, ofs_d;    // start offset for the next pushed line

  logic                redirect;
  logic [31:0]         target;
  logic [31:0]         tgt_line;
  logic                push, pop, flush;
  logic [FE_CNT_W-1:0] count, count_next;
  fe_entry_t           push_entry, head;
  logic                unused_bits;

  assign redirect    = ld_eip[1];
  assign target      = r_CS_base + r_EIP;
  assign tgt_line    = fe_line_of(target);
  assign unused_bits = ld_eip[0];

  // Lines are only accepted in RUN, and a same-cycle redirect discards the line.
  assign push       = (state_q == ST_RUN) & ~redirect & req_q & ic_ack;
  assign pop        = de_consume & fe_line_v;
  assign flush      = redirect;
  assign count_next = count + FE_CNT_W'(push) - FE_CNT_W'(pop);

  assign push_entry = '{data: ic_data, addr: addr_q, ofs: ofs_q};

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    tgt_d   = tgt_q;
    ofs_d   = ofs_q;
    case (state_q)
      ST_RUN: begin
        if (redirect) begin
          ofs_d = target[3:0];
          if (req_q && !ic_ack) begin
            // A request is in flight. Keep it on the bus and remember the target.
            state_d = ST_DRAIN;
            tgt_d   = tgt_line;
          end else begin
            addr_d = tgt_line;
            req_d  = 1'b1;
          end
        end else begin
          if (push) begin
            addr_d = addr_q + 32'(FE_LINE_BYTES);
            ofs_d  = 4'h0;
          end
          if (!req_q || ic_ack) begin
            req_d = (count_next < FE_CNT_W'(FE_DEPTH));
          end
        end
      end
      ST_DRAIN: begin
        if (redirect) begin
          tgt_d = tgt_line;
          ofs_d = target[3:0];
        end
        if (ic_ack) begin
          // The stale line is dropped. Restart at the latest target, and let
          // a redirect in the ack cycle itself take precedence.
          state_d = ST_RUN;
          addr_d  = redirect ? tgt_line : tgt_q;
          req_d   = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      req_q   <= 1'b0;
      addr_q  <= fe_line_of(RESET_VEC);
      tgt_q   <= fe_line_of(RESET_VEC);
      ofs_q   <= RESET_VEC[3:0];
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      tgt_q   <= tgt_d;
      ofs_q   <= ofs_d;
    end
  end

  fe_line_fifo #(
    .DEPTH (FE_DEPTH),
    .CW    (FE_CNT_W)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (push),
    .pop    (pop),
    .flush  (flush),
    .din    (push_entry),
    .count  (count),
    .head_v (fe_line_v),
    .head   (head)
  );

  assign ic_req       = req_q;
  assign ic_addr      = addr_q;
  assign fe_line      = head.data;
  assign fe_line_addr = head.addr;
  assign fe_ofs       = head.ofs;
  assign fe_busy      = (state_q == ST_DRAIN);

endmodule
